uart_frame_ctrl: RTL

- Sits downstream of the UART byte receiver. It consumes received bytes and their one-cycle done strobes.
- Parses framed write commands of the form header, address, length, payload and checksum, and buffers the payload.
- Once the checksum is verified, it sequences the buffered bytes into a register-write port using a valid/ready handshake.
- Uses the same 16x-baud clock enable as the receiver to detect stalled frames via an inter-byte timeout.

---
 rtl/uart_frame_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses 55 AA addr len payload sum frames and replays the payload as register writes
module uart_frame_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 160,
  parameter logic [7:0] HDR0 = 8'h55,
  parameter logic [7:0] HDR1 = 8'hAA
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clken_16bps,
  input  logic [7:0] rxd_data,
  input  logic       rxd_flag,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);
  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_ADDR, S_LEN, S_DATA, S_SUM, S_COMMIT} state_t;
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  state_t state, state_n;
  logic [7:0] idx, idx_n, sum, sum_n, base, base_n, len, len_n, wr_addr_n, wr_data_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0] code_n;
  logic wr_en_n, err_n, expire, last, we;
  logic [7:0] mem [MAX_LEN];
  assign last = idx == len - 8'd1;
  assign busy = state != S_HDR0;
  assign frame_ok = state == S_COMMIT && wr_en && wr_ready && last;
  // a byte arriving on the expiry tick wins over the timeout
  assign expire = !rxd_flag && clken_16bps && state != S_HDR0 && state != S_COMMIT && cnt == 16'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    idx_n = idx;
    sum_n = sum;
    base_n = base;
    len_n = len;
    wr_en_n = wr_en;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    err_n = 1'b0;
    code_n = err_code;
    we = 1'b0;
    cnt_n = (rxd_flag || expire || state == S_HDR0 || state == S_COMMIT) ? '0 : clken_16bps ? cnt + 16'd1 : cnt;
    if (expire) begin
      state_n = S_HDR0;
      err_n = 1'b1;
      code_n = 2'd3;
    end else if (rxd_flag) begin
      case (state)
        S_HDR0: state_n = rxd_data == HDR0 ? S_HDR1 : S_HDR0;
        S_HDR1: state_n = rxd_data == HDR1 ? S_ADDR : rxd_data == HDR0 ? S_HDR1 : S_HDR0;
        S_ADDR: begin
          base_n = rxd_data;
          sum_n = rxd_data;
          state_n = S_LEN;
        end
        S_LEN: begin
          if (rxd_data == 8'd0 || rxd_data > 8'(MAX_LEN)) begin
            err_n = 1'b1;
            code_n = 2'd1;
            state_n = S_HDR0;
          end else begin
            len_n = rxd_data;
            sum_n = sum + rxd_data;
            idx_n = 8'd0;
            state_n = S_DATA;
          end
        end
        S_DATA: begin
          we = 1'b1;
          sum_n = sum + rxd_data;
          idx_n = idx + 8'd1;
          state_n = last ? S_SUM : S_DATA;
        end
        S_SUM: begin
          if (rxd_data == sum) begin
            idx_n = 8'd0;
            state_n = S_COMMIT;
          end else begin
            err_n = 1'b1;
            code_n = 2'd2;
            state_n = S_HDR0;
          end
        end
        default: ;
      endcase
    end
    if (state == S_COMMIT) begin
      if (!wr_en) begin
        wr_en_n = 1'b1;
        wr_addr_n = base + idx;
        wr_data_n = mem[idx[IW-1:0]];
      end else if (wr_ready) begin
        if (last) begin
          wr_en_n = 1'b0;
          state_n = S_HDR0;
        end else begin
          idx_n = idx + 8'd1;
          wr_addr_n = base + idx_n;
          wr_data_n = mem[idx_n[IW-1:0]];
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_HDR0;
      idx <= '0;
      sum <= '0;
      base <= '0;
      len <= '0;
      cnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      frame_err <= 1'b0;
      err_code <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      sum <= sum_n;
      base <= base_n;
      len <= len_n;
      cnt <= cnt_n;
      wr_en <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      frame_err <= err_n;
      err_code <= code_n;
    end
  end
  always_ff @(posedge clk) if (we) mem[idx[IW-1:0]] <= rxd_data;
endmodule
